monopix2_cmd_tx: RTL

// DAQ-side command transmitter feeding the chip's LVDS_CMD input: takes 16-bit command frames

---
 rtl/monopix2_cmd_tx.sv | 105 ++++++++++
 1 files changed

// File: rtl/monopix2_cmd_tx.sv
// monopix2_cmd_tx
// DAQ-side serial command transmitter for the LVDS_CMD line. Takes 16-bit
// command frames over a valid/ready handshake and shifts them out MSB-first,
// one bit per CLK. The line always carries a frame: after reset it sends
// INIT_SYNC sync frames. After that it sends a sync frame every SYNC_INTERVAL
// non-sync frames. Otherwise it sends the offered command, or an idle frame
// when no command is available or EN=0.
//
// Ports
//   CLK          command bit clock (forwarded as LVDS_CMD_CLK)
//   RST          asynchronous active-high reset
//   EN           1 = commands may be accepted, 0 = only sync/idle frames
//   IN_DATA      command frame, bit 15 sent first
//   IN_VALID     IN_DATA holds a frame
//   IN_READY     frame taken this cycle when IN_VALID=1 (combinational)
//   CMD_OUT      registered serial stream
//   FRAME_START  registered pulse, CMD_OUT carries bit 15 of a new frame
//   INIT_DONE    initial sync sequence complete
//   CMD_CNT      accepted command frames, wraps at 2^32
module monopix2_cmd_tx #(
   parameter logic [15:0] SYNC_WORD     = 16'h817E,
   parameter logic [15:0] IDLE_WORD     = 16'hAAAA,
   parameter int unsigned INIT_SYNC     = 32,
   parameter int unsigned SYNC_INTERVAL = 32
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EN,
   input  logic [15:0] IN_DATA,
   input  logic        IN_VALID,
   output logic        IN_READY,
   output logic        CMD_OUT,
   output logic        FRAME_START,
   output logic        INIT_DONE,
   output logic [31:0] CMD_CNT
);

   localparam logic [31:0] INIT_N = 32'(INIT_SYNC);
   localparam logic [31:0] SYNC_N = 32'(SYNC_INTERVAL);

   logic [15:0] shreg;
   logic [3:0]  bit_cnt;
   logic        first;       // first cycle after reset is a load cycle
   logic [31:0] init_cnt;
   logic [15:0] since_sync;  // saturating, equality-compared only

   logic        load;
   logic        in_init;
   logic        sync_due;
   logic        accept;
   logic [15:0] next_frame;

   always_comb begin
      load       = first || (bit_cnt == 4'd0);
      in_init    = (init_cnt < INIT_N);
      sync_due   = (SYNC_N != 32'd0) && ({16'd0, since_sync} == SYNC_N);
      IN_READY   = load && INIT_DONE && !sync_due && EN && !RST;
      accept     = IN_READY && IN_VALID;
      next_frame = IDLE_WORD;
      if (in_init || sync_due)
         next_frame = SYNC_WORD;
      else if (accept)
         next_frame = IN_DATA;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shreg       <= '0;
         bit_cnt     <= 4'd15;
         first       <= 1'b1;
         CMD_OUT     <= 1'b0;
         FRAME_START <= 1'b0;
         INIT_DONE   <= 1'b0;
         CMD_CNT     <= '0;
         init_cnt    <= '0;
         since_sync  <= '0;
      end else if (load) begin
         // Bit 15 goes straight to CMD_OUT; the remaining 15 bits wait in shreg.
         first       <= 1'b0;
         bit_cnt     <= 4'd15;
         CMD_OUT     <= next_frame[15];
         shreg       <= {next_frame[14:0], 1'b0};
         FRAME_START <= 1'b1;
         if (in_init)
            init_cnt <= init_cnt + 32'd1;
         if (!in_init || (init_cnt == INIT_N - 32'd1))
            INIT_DONE <= 1'b1;
         // Init syncs do not count toward the periodic sync interval.
         if (!in_init) begin
            if (sync_due)
               since_sync <= '0;
            else if (since_sync != 16'hFFFF)
               since_sync <= since_sync + 16'd1;
         end
         if (accept)
            CMD_CNT <= CMD_CNT + 32'd1;
      end else begin
         bit_cnt     <= bit_cnt - 4'd1;
         CMD_OUT     <= shreg[15];
         shreg       <= {shreg[14:0], 1'b0};
         FRAME_START <= 1'b0;
      end
   end

endmodule
